// File: rtl/uart_msg_arbiter_if.sv
// Event-source / formatter bus for uart_msg_arbiter; slave = arbiter side, master = sources + formatter.
// UART_ARB_OVERRUN_EN adds the overrun / overrun_clr pair.
interface uart_msg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      fmt_busy;
  logic                      fmt_start;
  logic [DATA_W-1:0]         fmt_din;
  logic [ID_W-1:0]           grant_id;
  logic                      active;
  logic [NUM_REQ-1:0]        pending;
`ifdef UART_ARB_OVERRUN_EN
  logic [NUM_REQ-1:0]        overrun;
  logic                      overrun_clr;

  modport slave (
    input  req, req_data, fmt_busy, overrun_clr,
    output fmt_start, fmt_din, grant_id, active, pending, overrun
  );
  modport master (
    output req, req_data, fmt_busy, overrun_clr,
    input  fmt_start, fmt_din, grant_id, active, pending, overrun
  );
`else
  modport slave (
    input  req, req_data, fmt_busy,
    output fmt_start, fmt_din, grant_id, active, pending
  );
  modport master (
    output req, req_data, fmt_busy,
    input  fmt_start, fmt_din, grant_id, active, pending
  );
`endif
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one UART hex formatter among NUM_REQ event sources.
// Optional sticky overrun flags under UART_ARB_OVERRUN_EN.
module uart_msg_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int START_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_msg_arbiter_if.slave    bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_WAIT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    rr, win, grant_id_q;
  logic               found, load;
  logic [NUM_REQ-1:0] pending, grant_clr;
  logic [DATA_W-1:0]  data_q [NUM_REQ];
  logic [DATA_W-1:0]  fmt_din_q;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               fmt_start_q;

  // Search begins one past the last winner so every source gets a turn per rotation.
  always_comb begin
    int idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    grant_clr = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          load           = 1'b1;
          grant_clr[win] = 1'b1;
          state_nx       = S_START;
        end
      end
      S_START: begin
        cnt_nx   = '0;
        state_nx = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.fmt_busy) begin
          state_nx = S_WAIT_DONE;
        end else begin
          if (cnt != '1) cnt_nx = cnt + CNT_W'(1);
          // Formatter never acknowledged the start; give up and move on.
          if (cnt == CNT_W'(START_WAIT - 1)) state_nx = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.fmt_busy) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr          <= ID_W'(NUM_REQ - 1);
      pending     <= '0;
      cnt         <= '0;
      fmt_start_q <= 1'b0;
      fmt_din_q   <= '0;
      grant_id_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) data_q[i] <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      fmt_start_q <= load;
      // A new request on the grant cycle re-arms the source.
      pending     <= (pending & ~grant_clr) | bus.req;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i]) data_q[i] <= bus.req_data[DATA_W*i +: DATA_W];
      end
      if (load) begin
        rr         <= win;
        fmt_din_q  <= data_q[win];
        grant_id_q <= win;
      end
    end
  end

`ifdef UART_ARB_OVERRUN_EN
  logic [NUM_REQ-1:0] overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= (bus.overrun_clr ? '0 : overrun_q) | (bus.req & pending & ~grant_clr);
    end
  end

  assign bus.overrun = overrun_q;
`endif

  assign bus.fmt_start = fmt_start_q;
  assign bus.fmt_din   = fmt_din_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.active    = (state != S_IDLE);
  assign bus.pending   = pending;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Directed bench for uart_msg_arbiter with a simple busy-for-N-cycles formatter model.
module tb_uart_msg_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int START_WAIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_msg_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

  uart_msg_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .START_WAIT(START_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic busy_m   = 1'b0;
  int   bcnt     = 0;
  int   busy_len = 10;
  bit   fmt_en   = 1'b1;
  int   ncyc     = 0;
  int   log_id[$];
  int   log_din[$];
  int   log_cyc[$];
  int   fall_cyc[$];

  assign bus.fmt_busy = busy_m;

  // Formatter model: busy rises with the start pulse and stays high busy_len cycles.
  always @(negedge clk) begin
    ncyc++;
    if (bus.fmt_start === 1'b1) begin
      log_id.push_back(int'(bus.grant_id));
      log_din.push_back(int'(bus.fmt_din));
      log_cyc.push_back(ncyc);
      if (fmt_en) begin
        busy_m = 1'b1;
        bcnt   = busy_len;
      end
    end else if (busy_m) begin
      bcnt--;
      if (bcnt == 0) begin
        busy_m = 1'b0;
        fall_cyc.push_back(ncyc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_id.delete();
    log_din.delete();
    log_cyc.delete();
    fall_cyc.delete();
  endtask

  task automatic do_reset();
    bus.req      = '0;
    bus.req_data = '0;
`ifdef UART_ARB_OVERRUN_EN
    bus.overrun_clr = 1'b0;
`endif
    fmt_en = 1'b1;
    for (int i = 0; i < 300 && busy_m; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic pulse_req(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*DATA_W-1:0] data);
    bus.req      = mask;
    bus.req_data = data;
    tick();
    bus.req = '0;
  endtask

  task automatic wait_quiet(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!bus.active && bus.pending == '0 && !busy_m) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.req      = '0;
    bus.req_data = '0;
`ifdef UART_ARB_OVERRUN_EN
    bus.overrun_clr = 1'b0;
`endif
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.fmt_start, bus.active, bus.pending, bus.grant_id, bus.fmt_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b active=%b pending=%b id=%0d din=%h, required all 0",
               bus.fmt_start, bus.active, bus.pending, bus.grant_id, bus.fmt_din);
    end
`ifdef UART_ARB_OVERRUN_EN
    checks++;
    if (bus.overrun !== 4'b0000) begin
      errors++;
      $display("FAIL reset_overrun: got %b, required 0000", bus.overrun);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    busy_len = 100;
    pulse_req(4'b0010, 32'h0000_2300);
    checks++;
    if (bus.pending !== 4'b0010 || bus.fmt_start !== 1'b0) begin
      errors++;
      $display("FAIL single_pending: pending=%b start=%b, required 0010/0", bus.pending, bus.fmt_start);
    end
    tick();
    checks++;
    if (bus.fmt_start !== 1'b1 || bus.fmt_din !== 8'h23 || bus.grant_id !== 2'd1 || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: start=%b din=%h id=%0d active=%b, required 1/23/1/1",
               bus.fmt_start, bus.fmt_din, bus.grant_id, bus.active);
    end
    tick();
    checks++;
    if (bus.fmt_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_width: start=%b one cycle later, required 0", bus.fmt_start);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_m) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_fall: ok=%b active=%b when busy fell, required 1/1", ok, bus.active);
    end
    tick();
    checks++;
    if (bus.active !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: active=%b one cycle after busy fell, required 0", bus.active);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_din[4] = '{'h10, 'h21, 'h32, 'h43};
    do_reset();
    busy_len = 10;
    pulse_req(4'b1111, 32'h4332_2110);
    wait_quiet(500, ok);
    checks++;
    if (!ok || log_id.size() != 4 || fall_cyc.size() != 4) begin
      errors++;
      $display("FAIL rr_count: done=%b grants=%0d falls=%0d, required 1/4/4", ok, log_id.size(), fall_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_id[i] != i || log_din[i] != exp_din[i]) begin
          errors++;
          $display("FAIL rr_grant%0d: id=%0d din=%h, required %0d/%h", i, log_id[i], log_din[i], i, exp_din[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (log_cyc[i] - fall_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL rr_gap%0d: start-fall=%0d, required 2", i, log_cyc[i] - fall_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_overwrite();
    bit ok;
    do_reset();
    busy_len = 30;
    pulse_req(4'b0001, 32'h0000_0001);
    repeat (6) tick();
    pulse_req(4'b0100, 32'h0055_0000);
    repeat (3) tick();
`ifdef UART_ARB_OVERRUN_EN
    checks++;
    if (bus.overrun !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_first: overrun=%b after single req, required 0000", bus.overrun);
    end
`endif
    pulse_req(4'b0100, 32'h0066_0000);
    tick();
    checks++;
    if (bus.pending !== 4'b0100) begin
      errors++;
      $display("FAIL ovw_pending: pending=%b, required 0100", bus.pending);
    end
`ifdef UART_ARB_OVERRUN_EN
    checks++;
    if (bus.overrun !== 4'b0100) begin
      errors++;
      $display("FAIL ovr_set: overrun=%b, required 0100", bus.overrun);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    checks++;
    if (bus.overrun !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_clr: overrun=%b, required 0000", bus.overrun);
    end
`endif
    wait_quiet(300, ok);
    checks++;
    if (!ok || log_id.size() != 2) begin
      errors++;
      $display("FAIL ovw_count: done=%b grants=%0d, required 1/2", ok, log_id.size());
    end else begin
      checks++;
      if (log_id[1] != 2 || log_din[1] != 'h66) begin
        errors++;
        $display("FAIL ovw_data: id=%0d din=%h, required 2/66", log_id[1], log_din[1]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    fmt_en = 1'b0;
    pulse_req(4'b0010, 32'h0000_4D00);
    tick();
    checks++;
    if (bus.fmt_start !== 1'b1 || bus.grant_id !== 2'd1) begin
      errors++;
      $display("FAIL to_first: start=%b id=%0d, required 1/1", bus.fmt_start, bus.grant_id);
    end
    pulse_req(4'b1000, 32'h9C00_0000);
    n = 1;
    while (bus.active === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != START_WAIT + 1) begin
      errors++;
      $display("FAIL to_length: idle reached %0d cycles after start, required %0d", n, START_WAIT + 1);
    end
    tick();
    checks++;
    if (bus.fmt_start !== 1'b1 || bus.grant_id !== 2'd3 || bus.fmt_din !== 8'h9C) begin
      errors++;
      $display("FAIL to_next: start=%b id=%0d din=%h, required 1/3/9c", bus.fmt_start, bus.grant_id, bus.fmt_din);
    end
    fmt_en = 1'b1;
  endtask

  task automatic test_collision();
    bit ok;
    do_reset();
    busy_len = 10;
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_007A;
    tick();
    bus.req_data = 32'h0000_007B;
    tick();
    bus.req = '0;
    checks++;
    if (bus.fmt_start !== 1'b1 || bus.fmt_din !== 8'h7A || bus.pending !== 4'b0001) begin
      errors++;
      $display("FAIL col_grant: start=%b din=%h pending=%b, required 1/7a/0001",
               bus.fmt_start, bus.fmt_din, bus.pending);
    end
`ifdef UART_ARB_OVERRUN_EN
    checks++;
    if (bus.overrun !== 4'b0000) begin
      errors++;
      $display("FAIL col_overrun: overrun=%b, required 0000", bus.overrun);
    end
`endif
    wait_quiet(300, ok);
    checks++;
    if (!ok || log_id.size() != 2) begin
      errors++;
      $display("FAIL col_count: done=%b grants=%0d, required 1/2", ok, log_id.size());
    end else begin
      checks++;
      if (log_id[1] != 0 || log_din[1] != 'h7B) begin
        errors++;
        $display("FAIL col_second: id=%0d din=%h, required 0/7b", log_id[1], log_din[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    busy_len = 40;
    pulse_req(4'b0001, 32'h0000_0011);
    repeat (4) tick();
    pulse_req(4'b1010, 32'hAA00_BB00);
    checks++;
    if (bus.pending !== 4'b1010 || bus.active !== 1'b1 || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: pending=%b active=%b busy=%b, required 1010/1/1", bus.pending, bus.active, busy_m);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.fmt_start, bus.active, bus.pending, bus.grant_id, bus.fmt_din} !== '0) begin
      errors++;
      $display("FAIL mid_reset: start=%b active=%b pending=%b id=%0d din=%h, required all 0",
               bus.fmt_start, bus.active, bus.pending, bus.grant_id, bus.fmt_din);
    end
    tick();
    rst = 1'b0;
    n0 = log_id.size();
    repeat (60) tick();
    checks++;
    if (log_id.size() != n0 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet: starts after reset=%0d active=%b, required 0/0", log_id.size() - n0, bus.active);
    end
    pulse_req(4'b1000, 32'h3E00_0000);
    tick();
    checks++;
    if (bus.fmt_start !== 1'b1 || bus.grant_id !== 2'd3 || bus.fmt_din !== 8'h3E) begin
      errors++;
      $display("FAIL mid_new: start=%b id=%0d din=%h, required 1/3/3e", bus.fmt_start, bus.grant_id, bus.fmt_din);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overwrite();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
